instr_wb_master: RTL

Instrumented Wishbone B4 pipelined master for testbenches: it turns one command from the instrumentation interface into a single or incrementing-burst read/write on a Wishbone bus. It honours slave stall, counts outstanding acknowledges, returns read data beat by beat and aborts on a configurable ack timeout. It is the initiator-side counterpart used to drive the bus slaves under test.

---
 rtl/instr_wb_master_if.sv | 26 ++
 rtl/instr_wb_master.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_wb_master_if.sv
// Wishbone B4 pipelined bus bundle between the instrumented master and a slave.
interface instr_wb_master_if;
  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  logic [ADR_W-1:0] wb_adr_o;
  logic [DAT_W-1:0] wb_dat_o;
  logic [DAT_W-1:0] wb_dat_i;
  logic             wb_we_o;
  logic [SEL_W-1:0] wb_sel_o;
  logic             wb_stb_o;
  logic             wb_ack_i;
  logic             wb_cyc_o;
  logic             wb_stall_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i, wb_stall_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i, wb_stall_i
  );
endinterface

// File: rtl/instr_wb_master.sv
// Instrumented Wishbone B4 pipelined master: one command becomes a single or
// incrementing burst, with stall handling, ack counting and an ack timeout.
module instr_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  instr_wb_master_if.master        wb,
  input  logic                     request_i,
  input  logic                     req_we_i,
  input  logic [31:0]              req_adr_i,
  input  logic [31:0]              req_dat_i,
  input  logic [3:0]               req_sel_i,
  input  logic [4:0]               req_len_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     timeout_o,
  output logic                     rd_valid_o,
  output logic [31:0]              rd_data_o
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned LW = 5;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic            we_q, we_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   iss_q, iss_d;
  logic [LW-1:0]   ack_cnt_q, ack_cnt_d;
  logic [TW-1:0]   to_q, to_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tout_q, tout_d;
  logic            rdv_q, rdv_d;
  logic [DW-1:0]   rdat_q, rdat_d;

  logic            accept_c;
  logic            ack_hit_c;
  logic            to_hit_c;

  // Beat handshake, counted ack (extra acks beyond len dropped) and timeout expiry.
  assign accept_c  = stb_q && !wb.wb_stall_i;
  assign ack_hit_c = cyc_q && wb.wb_ack_i && (ack_cnt_q != len_q);
  assign to_hit_c  = (TIMEOUT_CYCLES != 0) && (TW'(to_q + TW'(1)) == TW'(TIMEOUT_CYCLES));

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    sel_d     = sel_q;
    len_d     = len_q;
    iss_d     = iss_q;
    ack_cnt_d = ack_cnt_q;
    to_d      = to_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    busy_d    = busy_q;
    rdat_d    = rdat_q;
    done_d    = 1'b0;
    tout_d    = 1'b0;
    rdv_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (request_i) begin
          we_d      = req_we_i;
          adr_d     = req_adr_i;
          dat_d     = req_dat_i;
          sel_d     = req_sel_i;
          len_d     = (req_len_i == '0) ? LW'(1) : req_len_i;
          iss_d     = '0;
          ack_cnt_d = '0;
          to_d      = '0;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE, S_DRAIN: begin
        if (accept_c) begin
          iss_d = LW'(iss_q + LW'(1));
          adr_d = AW'(adr_q + AW'(4));
          if (LW'(iss_q + LW'(1)) == len_q) begin
            stb_d   = 1'b0;
            state_d = S_DRAIN;
          end
        end
        if (ack_hit_c) begin
          ack_cnt_d = LW'(ack_cnt_q + LW'(1));
          to_d      = '0;
          rdat_d    = wb.wb_dat_i;
          rdv_d     = !we_q;
          if (LW'(ack_cnt_q + LW'(1)) == len_q) begin
            state_d = S_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          to_d = TW'(to_q + TW'(1));
          if (to_hit_c) begin
            state_d = S_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tout_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any cycle in flight silently.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      len_q     <= '0;
      iss_q     <= '0;
      ack_cnt_q <= '0;
      to_q      <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tout_q    <= 1'b0;
      rdv_q     <= 1'b0;
      rdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      len_q     <= len_d;
      iss_q     <= iss_d;
      ack_cnt_q <= ack_cnt_d;
      to_q      <= to_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tout_q    <= tout_d;
      rdv_q     <= rdv_d;
      rdat_q    <= rdat_d;
    end
  end

  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_cyc_o = cyc_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = tout_q;
  assign rd_valid_o  = rdv_q;
  assign rd_data_o   = rdat_q;

endmodule
